// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and sequence-detector stages.
package seq_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Pattern the downstream detector searches for, MSB presented first.
  localparam int unsigned   DET_PATTERN_LEN = 4;
  localparam logic [3:0]    DET_PATTERN     = 4'b1101;

  // Bits needed to count 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: one WIDTH-bit word in, one bit per accepted cycle out.
// First bit appears the cycle after the load; back-to-back words stream with no bubble.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_last,
  output logic             busy
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             vld_q,   vld_d;

  logic last;
  logic advance;
  logic load;

  assign last    = vld_q && (cnt_q == CNT_LAST);
  assign advance = vld_q && bit_ready;

  // Ready looks through bit_ready so the next word loads on the final-bit cycle.
  assign in_ready = !rst && ((state_q == ST_IDLE) || (advance && last));
  assign load     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    if (load) begin
      sreg_d  = in_data;
      cnt_d   = '0;
      state_d = ST_SHIFT;
      vld_d   = 1'b1;
    end else if (advance) begin
      sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
      if (last) begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  assign bit_out   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign bit_valid = vld_q;
  assign bit_last  = last;
  assign busy      = vld_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench: stimulus pushes expected {bit,last} pairs, a monitor pops them on each consumed bit.
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] m_in_data,  l_in_data;
  logic       m_in_valid, l_in_valid;
  logic       m_in_ready, l_in_ready;
  logic       m_bit_out,  l_bit_out;
  logic       m_bit_valid, l_bit_valid;
  logic       m_bit_ready, l_bit_ready;
  logic       m_bit_last, l_bit_last;
  logic       m_busy,     l_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_m[$];
  logic [1:0] exp_l[$];

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst),
    .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .bit_out(m_bit_out), .bit_valid(m_bit_valid), .bit_ready(m_bit_ready),
    .bit_last(m_bit_last), .busy(m_busy)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst),
    .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .bit_out(l_bit_out), .bit_valid(l_bit_valid), .bit_ready(l_bit_ready),
    .bit_last(l_bit_last), .busy(l_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-expanded expected bit sequences; last flag set only on the 8th bit.
  task automatic push_bits(input bit to_lsb, input logic [7:0] bits_in_order);
    for (int k = 0; k < 8; k++) begin
      if (to_lsb) exp_l.push_back({bits_in_order[7-k], (k == 7) ? 1'b1 : 1'b0});
      else        exp_m.push_back({bits_in_order[7-k], (k == 7) ? 1'b1 : 1'b0});
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst && m_bit_valid && m_bit_ready) begin
      if (exp_m.size() == 0) chk("m_unexpected_bit", 32'd1, 32'd0);
      else begin
        e = exp_m.pop_front();
        chk("m_bit_out", {31'd0, m_bit_out}, {31'd0, e[1]});
        chk("m_bit_last", {31'd0, m_bit_last}, {31'd0, e[0]});
        chk("m_busy", {31'd0, m_busy}, 32'd1);
      end
    end
    if (!rst && l_bit_valid && l_bit_ready) begin
      if (exp_l.size() == 0) chk("l_unexpected_bit", 32'd1, 32'd0);
      else begin
        e = exp_l.pop_front();
        chk("l_bit_out", {31'd0, l_bit_out}, {31'd0, e[1]});
        chk("l_bit_last", {31'd0, l_bit_last}, {31'd0, e[0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    m_in_data = '0; m_in_valid = 1'b0; m_bit_ready = 1'b1;
    l_in_data = '0; l_in_valid = 1'b0; l_bit_ready = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_bit_valid", {31'd0, m_bit_valid}, 32'd0);
    chk("rst_bit_out",   {31'd0, m_bit_out},   32'd0);
    chk("rst_bit_last",  {31'd0, m_bit_last},  32'd0);
    chk("rst_busy",      {31'd0, m_busy},      32'd0);
    chk("rst_in_ready",  {31'd0, m_in_ready},  32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, m_in_ready}, 32'd1);

    // Single word 0xD0, MSB first: 1,1,0,1,0,0,0,0
    m_in_data = 8'hD0; m_in_valid = 1'b1;
    push_bits(1'b0, 8'b1101_0000);
    tick();
    m_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("single_valid", {31'd0, m_bit_valid}, 32'd1);
      chk("single_in_ready", {31'd0, m_in_ready}, (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    chk("single_done_valid", {31'd0, m_bit_valid}, 32'd0);

    // Back-to-back 0xD0 then 0x0D: 16 gap-free bits
    m_in_data = 8'hD0; m_in_valid = 1'b1;
    push_bits(1'b0, 8'b1101_0000);
    push_bits(1'b0, 8'b0000_1101);
    tick();
    m_in_data = 8'h0D;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_valid", {31'd0, m_bit_valid}, 32'd1);
      chk("b2b_in_ready", {31'd0, m_in_ready}, (i == 7 || i == 15) ? 32'd1 : 32'd0);
      tick();
      if (i == 7) m_in_valid = 1'b0;
    end
    chk("b2b_done_valid", {31'd0, m_bit_valid}, 32'd0);

    // Backpressure after the 2nd bit: 3rd bit (0) holds for 3 cycles
    m_in_data = 8'hD0; m_in_valid = 1'b1;
    push_bits(1'b0, 8'b1101_0000);
    tick();
    m_in_valid = 1'b0;
    tick(); tick();
    m_bit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_out",   {31'd0, m_bit_out},   32'd0);
      chk("bp_hold_valid", {31'd0, m_bit_valid}, 32'd1);
      chk("bp_hold_last",  {31'd0, m_bit_last},  32'd0);
      chk("bp_in_ready",   {31'd0, m_in_ready},  32'd0);
      tick();
    end
    m_bit_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_done_valid", {31'd0, m_bit_valid}, 32'd0);

    // LSB-first instance, 0x0B: 1,1,0,1,0,0,0,0
    l_in_data = 8'h0B; l_in_valid = 1'b1;
    push_bits(1'b1, 8'b1101_0000);
    tick();
    l_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_valid", {31'd0, l_bit_valid}, 32'd1);
      tick();
    end
    chk("lsb_done_valid", {31'd0, l_bit_valid}, 32'd0);

    // Reset after 3 bits of 0xFF: the rest is discarded
    m_in_data = 8'hFF; m_in_valid = 1'b1;
    push_bits(1'b0, 8'hFF);
    tick();
    m_in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    exp_m.delete();
    tick();
    chk("mid_rst_valid",    {31'd0, m_bit_valid}, 32'd0);
    chk("mid_rst_out",      {31'd0, m_bit_out},   32'd0);
    chk("mid_rst_in_ready", {31'd0, m_in_ready},  32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_release_ready", {31'd0, m_in_ready}, 32'd1);
    tick(); tick();
    chk("mid_rst_no_resume", {31'd0, m_bit_valid}, 32'd0);
    m_in_data = 8'h81; m_in_valid = 1'b1;
    push_bits(1'b0, 8'h81);
    tick();
    m_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("after_rst_last", {31'd0, m_bit_last}, (i == 7) ? 32'd1 : 32'd0);
      tick();
    end

    // Upstream stalls with 0xAA while a word is in flight
    m_in_data = 8'hD0; m_in_valid = 1'b1;
    push_bits(1'b0, 8'b1101_0000);
    tick();
    m_in_valid = 1'b0;
    tick(); tick();
    m_in_data = 8'hAA; m_in_valid = 1'b1;
    push_bits(1'b0, 8'hAA);
    for (int i = 2; i < 8; i++) begin
      chk("stall_in_ready", {31'd0, m_in_ready}, (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    m_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("stall_word_valid", {31'd0, m_bit_valid}, 32'd1);
      chk("stall_word_last",  {31'd0, m_bit_last}, (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    chk("stall_done_valid", {31'd0, m_bit_valid}, 32'd0);

    tick(); tick();
    chk("m_queue_drained", exp_m.size(), 32'd0);
    chk("l_queue_drained", exp_l.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
